// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

  localparam int SERIAL_ADDER_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell used as the serial adder's bit datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one full_adder.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > SERIAL_ADDER_MAX_WIDTH) begin : g_width_check
    $error("serial_adder: WIDTH %0d outside 2..%0d", WIDTH, SERIAL_ADDER_MAX_WIDTH);
  end

  state_t state, next_state;

  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, b_load;
  logic [CNT_W-1:0] cnt;
  logic             carry_q, cin_load;
  logic             fa_sum, fa_carry;
  logic             accept, last_bit;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1, so the caller's cin is overridden.
  assign b_load   = sub ? ~b : b;
  assign cin_load = sub | cin;
`else
  assign b_load   = b;
  assign cin_load = cin;
`endif

  full_adder u_full_adder (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
          accept     = 1'b1;
        end
      end
      RUN: begin
        if (cnt == LAST_BIT) begin
          next_state = DONE;
          last_bit   = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // busy/done are registered from next_state so start never reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
      done <= (next_state == DONE);
      if (accept) begin
        a_sr    <= a;
        b_sr    <= b_load;
        carry_q <= cin_load;
        cnt     <= '0;
      end else if (state == RUN) begin
        a_sr    <= a_sr >> 1;
        b_sr    <= b_sr >> 1;
        carry_q <= fa_carry;
        cnt     <= cnt + CNT_W'(1);
        sum_sr  <= {fa_sum, sum_sr[WIDTH-1:1]};
        if (last_bit) begin
          sum  <= {fa_sum, sum_sr[WIDTH-1:1]};
          cout <= fa_carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH=8 and WIDTH=13.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, cin, sub;
  logic [7:0]  a, b;
  logic        busy, done, cout;
  logic [7:0]  sum;

  logic        start13, cin13;
  logic [12:0] a13, b13;
  logic        busy13, done13, cout13;
  logic [12:0] sum13;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder #(.WIDTH(13)) dut13 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start13),
    .a     (a13),
    .b     (b13),
    .cin   (cin13),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (1'b0),
`endif
    .busy  (busy13),
    .done  (done13),
    .sum   (sum13),
    .cout  (cout13)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; the request is accepted on the following posedge.
  task automatic applyStimulus(input logic [7:0] op_a, input logic [7:0] op_b,
                               input logic op_c, input logic op_sub);
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    cin   = op_c;
    sub   = op_sub;
    @(negedge clk);
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    cin   = 1'b0;
  endtask

  // Entered in the first busy cycle; leaves one cycle after done.
  task automatic waitResult(input string tag, input logic [8:0] expected);
    int waited = 1;
    while (done !== 1'b1 && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_latency"}, waited, 9);
    checkOutput({tag, "_sum"}, sum, expected[7:0]);
    checkOutput({tag, "_cout"}, cout, expected[8]);
    @(negedge clk);
  endtask

  initial begin
    int          done_seen;
    int          waited;
    logic [7:0]  ra, rb;
    logic        rc;
    logic [13:0] exp13;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    start13 = 1'b0; a13 = '0; b13 = '0; cin13 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_sum", sum, 0);
    checkOutput("reset_cout", cout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed 0x5A+0x3C with per-cycle busy/done");
    applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0);
    checkOutput("e1_busy", busy, 1);
    checkOutput("e1_done", done, 0);
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      checkOutput("run_busy", busy, 1);
      checkOutput("run_done", done, 0);
    end
    @(negedge clk);
    checkOutput("e9_done", done, 1);
    checkOutput("e9_busy", busy, 1);
    checkOutput("e9_sum", sum, 8'h96);
    checkOutput("e9_cout", cout, 0);
    @(negedge clk);
    checkOutput("e10_busy", busy, 0);
    checkOutput("e10_done", done, 0);
    checkOutput("e10_sum_held", sum, 8'h96);

    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
    waitResult("ripple", 9'h100);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0);
    waitResult("allones", 9'h1FF);

    $display("[TB] start pulses while busy are ignored");
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
    done_seen = 0;
    @(negedge clk);
    done_seen += int'(done);
    @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'hAA; cin = 1'b1;
    done_seen += int'(done);
    @(negedge clk);
    start = 1'b0;
    done_seen += int'(done);
    repeat (5) begin
      @(negedge clk);
      done_seen += int'(done);
    end
    checkOutput("ign_e9_done", done, 1);
    checkOutput("ign_sum", sum, 8'h12 + 8'h34);
    checkOutput("ign_cout", cout, 0);
    start = 1'b1; a = 8'h20; b = 8'h03; cin = 1'b1;
    @(negedge clk);
    done_seen += int'(done);
    checkOutput("ign_done_count", done_seen, 1);
    checkOutput("ign_e10_busy", busy, 0);
    @(negedge clk);
    start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    checkOutput("new_accept_busy", busy, 1);
    waitResult("after_ignore", 9'h024);

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_sum", sum, 0);
    checkOutput("arst_cout", cout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      done_seen += int'(done);
    end
    checkOutput("arst_no_done", done_seen, 0);
    applyStimulus(8'hC3, 8'h5E, 1'b1, 1'b0);
    waitResult("post_reset", 9'h122);

`ifdef SERIAL_ADDER_SUB_EN
    $display("[TB] subtract mode");
    applyStimulus(8'h10, 8'h01, 1'b0, 1'b1);
    waitResult("sub_noborrow", 9'h10F);
    applyStimulus(8'h01, 8'h02, 1'b1, 1'b1);
    waitResult("sub_borrow", 9'h0FF);
`endif

    $display("[TB] 1000 back-to-back random runs, WIDTH=8");
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      applyStimulus(ra, rb, rc, 1'b0);
      waitResult("rand8", {1'b0, ra} + {1'b0, rb} + 9'(rc));
    end

    $display("[TB] 1000 back-to-back random runs, WIDTH=13");
    for (int i = 0; i < 1000; i++) begin
      a13     = 13'($urandom);
      b13     = 13'($urandom);
      cin13   = 1'($urandom);
      exp13   = {1'b0, a13} + {1'b0, b13} + 14'(cin13);
      start13 = 1'b1;
      @(negedge clk);
      start13 = 1'b0;
      a13     = '0;
      b13     = '0;
      cin13   = 1'b0;
      waited  = 1;
      while (done13 !== 1'b1 && waited < 18) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("rand13_latency", waited, 14);
      checkOutput("rand13_sum", sum13, exp13[12:0]);
      checkOutput("rand13_cout", cout13, exp13[13]);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
